aha_uart_rx_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the CMSDK UART RXD pin inside the AHA SoC peripheral subsystem.
- Synchronises the asynchronous pad-level receive line into the PCLK domain.
- Removes glitches shorter than a programmable sample count.
- Detects line-break conditions (line held low for a long time) and counts rejected glitches for software diagnostics.
- Output RXD connects straight to the UART RXD input; interrupts go to the SoC interrupt fabric.

---
 rtl/aha_uart_rx_conditioner.sv | 172 +++++++++++++++++
 tb/tb_aha_uart_rx_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aha_uart_rx_conditioner.sv
// RXD pad conditioner for the CMSDK UART: synchroniser, glitch filter, break detector
// and glitch counter. Define AHA_UART_RX_BREAK_MASK_EN to hold RXD at mark during BREAK.
module aha_uart_rx_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int BRK_CNT_W    = 16,
  parameter int GLITCH_CNT_W = 8
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PCLKEN,
  input  logic                    RXD_PAD,
  input  logic [BRK_CNT_W-1:0]    BREAK_LEN,
  input  logic                    GLITCH_CLR,
  output logic                    RXD,
  output logic                    BREAK_DET,
  output logic                    BREAK_INT,
  output logic [GLITCH_CNT_W-1:0] GLITCH_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    BREAK = 2'd2
  } state_t;

  localparam logic [3:0]              FLEN    = 4'(FILTER_LEN);
  localparam logic [3:0]              FONE    = 4'd1;
  localparam logic [BRK_CNT_W-1:0]    BRK_ONE = BRK_CNT_W'(1);
  localparam logic [GLITCH_CNT_W-1:0] GL_ONE  = GLITCH_CNT_W'(1);

  function automatic logic [BRK_CNT_W-1:0] sat_inc_brk(input logic [BRK_CNT_W-1:0] v);
    return (&v) ? v : v + BRK_ONE;
  endfunction

  function automatic logic [GLITCH_CNT_W-1:0] sat_inc_glitch(input logic [GLITCH_CNT_W-1:0] v);
    return (&v) ? v : v + GL_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sample;
  logic                   filtered;
  logic                   filt_nxt;
  logic                   filt_prev;
  logic [3:0]             fcnt;
  logic [3:0]             fcnt_nxt;
  logic [3:0]             fcnt_inc;
  logic                   glitch;
  state_t                 state;
  state_t                 state_nxt;
  logic [BRK_CNT_W-1:0]   bcnt;
  logic [BRK_CNT_W-1:0]   bcnt_nxt;
  logic                   len_on;
  logic                   rxd_nxt;

  // Stage p0: pad synchroniser, free-running regardless of PCLKEN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_p <= '1;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], RXD_PAD};
    end
  end

  assign sample   = sync_p[SYNC_STAGES-1];
  assign fcnt_inc = fcnt + FONE;
  assign len_on   = (BREAK_LEN != '0);

  // Stage p1: run-length glitch filter on qualified samples
  always_comb begin
    filt_nxt = filtered;
    fcnt_nxt = fcnt;
    glitch   = 1'b0;
    if (PCLKEN) begin
      if (sample != filtered) begin
        if (fcnt_inc == FLEN) begin
          filt_nxt = sample;
          fcnt_nxt = '0;
        end else begin
          fcnt_nxt = fcnt_inc;
        end
      end else if (fcnt != '0) begin
        fcnt_nxt = '0;
        glitch   = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      filtered  <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      filtered <= filt_nxt;
      fcnt     <= fcnt_nxt;
      if (PCLKEN) begin
        filt_prev <= filtered;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      GLITCH_CNT <= '0;
    end else if (GLITCH_CLR) begin
      GLITCH_CNT <= '0;
    end else if (glitch) begin
      GLITCH_CNT <= sat_inc_glitch(GLITCH_CNT);
    end
  end

  // Stage p2: break FSM watching the registered filtered level
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    if (PCLKEN) begin
      case (state)
        IDLE: begin
          if (!filtered && filt_prev && len_on) begin
            state_nxt = LOW;
            bcnt_nxt  = BRK_ONE;
          end
        end
        LOW: begin
          if (filtered || !len_on) begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
          end else if (bcnt == BREAK_LEN) begin
            state_nxt = BREAK;
          end else begin
            bcnt_nxt = sat_inc_brk(bcnt);
          end
        end
        BREAK: begin
          if (filtered || !len_on) begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          bcnt_nxt  = '0;
        end
      endcase
    end
  end

`ifdef AHA_UART_RX_BREAK_MASK_EN
  // Covering both current and next state keeps RXD at mark on the entry and exit edges.
  assign rxd_nxt = filtered | (state == BREAK) | (state_nxt == BREAK);
`else
  assign rxd_nxt = filtered;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      bcnt      <= '0;
      BREAK_DET <= 1'b0;
      BREAK_INT <= 1'b0;
      RXD       <= 1'b1;
    end else begin
      state     <= state_nxt;
      bcnt      <= bcnt_nxt;
      BREAK_DET <= (state_nxt == BREAK);
      BREAK_INT <= (state != BREAK) && (state_nxt == BREAK);
      RXD       <= rxd_nxt;
    end
  end

endmodule

// File: tb/tb_aha_uart_rx_conditioner.sv
// Self-checking bench for aha_uart_rx_conditioner: vector table, corner sequences and a
// randomized run, all checked every cycle against a behavioural model.
module tb_aha_uart_rx_conditioner;
  localparam int SYNC_STAGES  = 2;
  localparam int FILTER_LEN   = 3;
  localparam int BRK_CNT_W    = 16;
  localparam int GLITCH_CNT_W = 8;
  localparam int GL_MAX       = (1 << GLITCH_CNT_W) - 1;
`ifdef AHA_UART_RX_BREAK_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic                    PCLK = 1'b0;
  logic                    PRESET;
  logic                    PCLKEN;
  logic                    RXD_PAD;
  logic [BRK_CNT_W-1:0]    BREAK_LEN;
  logic                    GLITCH_CLR;
  logic                    RXD;
  logic                    BREAK_DET;
  logic                    BREAK_INT;
  logic [GLITCH_CNT_W-1:0] GLITCH_CNT;

  aha_uart_rx_conditioner #(
    .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN),
    .BRK_CNT_W(BRK_CNT_W), .GLITCH_CNT_W(GLITCH_CNT_W)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PCLKEN(PCLKEN), .RXD_PAD(RXD_PAD),
    .BREAK_LEN(BREAK_LEN), .GLITCH_CLR(GLITCH_CLR), .RXD(RXD),
    .BREAK_DET(BREAK_DET), .BREAK_INT(BREAK_INT), .GLITCH_CNT(GLITCH_CNT)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Model: pad delay line, run-length level tracker, "qualified cycles since the
  // conditioned line was first seen low" age, and the break/glitch bookkeeping.
  bit m_sh [SYNC_STAGES];
  bit m_lvl, m_prev, m_track, m_brk, m_int, m_rxd;
  int m_run, m_age, m_gcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) m_sh[i] = 1'b1;
    m_lvl = 1'b1; m_prev = 1'b1; m_track = 1'b0; m_brk = 1'b0;
    m_int = 1'b0; m_rxd = 1'b1; m_run = 0; m_age = 0; m_gcnt = 0;
  endtask

  task automatic model_step();
    bit s, lvl_old, lvl_new, g, brk_old;
    if (PRESET) begin
      model_reset();
      return;
    end
    s = m_sh[SYNC_STAGES-1];
    for (int i = SYNC_STAGES-1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = RXD_PAD;
    lvl_old = m_lvl; lvl_new = m_lvl; g = 1'b0; brk_old = m_brk; m_int = 1'b0;
    if (PCLKEN) begin
      if (s != m_lvl) begin
        m_run++;
        if (m_run == FILTER_LEN) begin lvl_new = s; m_run = 0; end
      end else if (m_run > 0) begin
        m_run = 0; g = 1'b1;
      end
      if (lvl_old || BREAK_LEN == 0) begin
        m_brk = 1'b0; m_track = 1'b0;
      end else if (m_prev) begin
        m_track = 1'b1; m_age = 0;
      end else if (m_track && !m_brk) begin
        m_age++;
        if (m_age == int'(BREAK_LEN)) begin m_brk = 1'b1; m_int = 1'b1; end
      end
      m_prev = lvl_old;
    end
    if (GLITCH_CLR) m_gcnt = 0;
    else if (g && m_gcnt < GL_MAX) m_gcnt++;
    m_rxd = (MASK && (brk_old || m_brk)) ? 1'b1 : lvl_old;
    m_lvl = lvl_new;
  endtask

  task automatic cycle(input bit pad, input bit en, input bit clr);
    RXD_PAD = pad; PCLKEN = en; GLITCH_CLR = clr;
    @(posedge PCLK);
    model_step();
    #1;
    check("rxd", RXD, m_rxd);
    check("break_det", BREAK_DET, m_brk);
    check("break_int", BREAK_INT, m_int);
    check("glitch_cnt", GLITCH_CNT, m_gcnt);
  endtask

  typedef struct {
    int low; int blen; int gl; int lowcyc; int ints; int detcyc;
  } vec_t;
  vec_t tbl [8];
  logic [BRK_CNT_W-1:0] blist [7];

  int g0, lc, ic, dc, fall_i, int_i, int_n, det_off, len;
  bit lvl;

  initial begin
    tbl[0] = '{1,    20, 1, 0, 0, 0};
    tbl[1] = '{2,    20, 1, 0, 0, 0};
    tbl[2] = '{3,    20, 0, 3, 0, 0};
    tbl[3] = '{19,   20, 0, 19, 0, 0};
    tbl[4] = '{21,   20, 0, MASK ? 20 : 21, 1, 1};
    tbl[5] = '{40,   20, 0, MASK ? 20 : 40, 1, 20};
    tbl[6] = '{3,    1,  0, MASK ? 1 : 3, 1, 2};
    tbl[7] = '{1000, 0,  0, 1000, 0, 0};
    blist  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd20};

    PRESET = 1'b1; PCLKEN = 1'b1; RXD_PAD = 1'b0; GLITCH_CLR = 1'b0; BREAK_LEN = 16'd20;
    model_reset();

    // Reset held with the pad low, then release and measure first RXD fall.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check("rst_rxd", RXD, 1);
      check("rst_det", BREAK_DET, 0);
      check("rst_int", BREAK_INT, 0);
      check("rst_gcnt", GLITCH_CNT, 0);
    end
    PRESET = 1'b0;
    fall_i = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (RXD == 1'b0 && fall_i < 0) fall_i = i;
    end
    check("rst_latency", fall_i, SYNC_STAGES + FILTER_LEN + 1);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1, 1'b0);

    // Vector table: one low pulse per row followed by a settling tail.
    for (int v = 0; v < 8; v++) begin
      BREAK_LEN = tbl[v].blen[BRK_CNT_W-1:0];
      g0 = int'(GLITCH_CNT); lc = 0; ic = 0; dc = 0;
      for (int i = 0; i < tbl[v].low + 40; i++) begin
        cycle(i >= tbl[v].low, 1'b1, 1'b0);
        if (RXD == 1'b0) lc++;
        if (BREAK_INT) ic++;
        if (BREAK_DET) dc++;
      end
      check("vec_glitch", int'(GLITCH_CNT) - g0, tbl[v].gl);
      check("vec_rxd_low", lc, tbl[v].lowcyc);
      check("vec_break_int", ic, tbl[v].ints);
      check("vec_break_det", dc, tbl[v].detcyc);
    end

    // Break timing relative to RXD fall and pad rise.
    BREAK_LEN = 16'd20; fall_i = -1; int_i = -1; int_n = 0; det_off = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (RXD == 1'b0 && fall_i < 0) fall_i = i;
      if (BREAK_INT) begin int_n++; int_i = i; end
      if (BREAK_DET) check("mask_rxd", RXD, MASK);
    end
    for (int j = 1; j <= 12; j++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (!BREAK_DET && det_off < 0) det_off = j;
    end
    check("brk_int_delay", int_i - fall_i, 20);
    check("brk_int_width", int_n, 1);
    check("brk_det_release", det_off, 6);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);

    // Glitch counter saturation, then clear colliding with a glitch event.
    for (int n = 0; n < 300; n++) begin
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
    end
    check("glitch_sat", GLITCH_CNT, GL_MAX);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    check("glitch_clr_prio", GLITCH_CNT, 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);

    // PCLKEN every 4th cycle with a short break length.
    BREAK_LEN = 16'd5; fall_i = -1; int_i = -1; int_n = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, (i % 4) == 0, 1'b0);
      if (RXD == 1'b0 && fall_i < 0) fall_i = i;
      if (BREAK_INT) begin int_n++; int_i = i; end
      if (BREAK_DET) check("gated_mask_rxd", RXD, MASK);
    end
    for (int i = 0; i < 60; i++) cycle(1'b1, (i % 4) == 0, 1'b0);
    check("gated_int_delay", int_i - fall_i, 23);
    check("gated_int_width", int_n, 1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);

    // Reset during BREAK: everything discarded, no pulse on release.
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0);
    check("pre_reset_det", BREAK_DET, 1);
    PRESET = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    PRESET = 1'b0; ic = 0; dc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (BREAK_INT) ic++;
      if (BREAK_DET) dc++;
    end
    check("post_reset_int", ic, 0);
    check("post_reset_det", dc, 0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0);

    // Randomized runs against the model.
    lvl = 1'b1;
    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(0, 3) == 0) BREAK_LEN = blist[$urandom_range(0, 6)];
      if ($urandom_range(0, 39) == 0) begin
        PRESET = 1'b1;
        cycle(lvl, 1'b1, 1'b0);
        cycle(lvl, 1'b1, 1'b0);
        PRESET = 1'b0;
      end
      lvl = ~lvl;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 80)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++)
        cycle(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
